c_d_seq_mc: RTL
===============

Name: c_d_seq_mc

Overview:
- Parametrised multi-channel capture/dump sequencer that drives a fault-injection demo.
- Each run: one capture pulse with an optional error-injection window, then each channel's buffered bytes dumped in turn to the serial transmitter, each preceded by a label header.
- Replaces the fixed 8-channel, busy-polled controller with a valid/ready serial handshake, per-channel sequential dump, programmable label/run count and a configurable injection window.

Parameters:
NUM_CH, 8, number of capture channels (1..16); CH_W = max(1, clog2(NUM_CH))
NUM_RUNS, 10, runs before demo_done (1..255)
LABEL_LEN, 4, header bytes per channel (>=4)
LABEL_BYTE, 8'hF0, filler header byte
ERR_FIRST, 2, first run index with injection enabled
ERR_LAST, 5, last run index with injection enabled (inclusive)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; run sequence may begin/continue while high
inj_err  in  8  [7] injection enable, [6:0] error select
ch_out  in  8*NUM_CH  flattened channel bytes, channel c at [8c+7:8c]
ch_out_vld  in  NUM_CH  channel c presents a valid byte
ch_out_done  in  NUM_CH  channel c drained (no further bytes)
serial_rdy  in  1  transmitter accepts byte this cycle
err_en  out  1  error-injection strobe
err_ctrl  out  9  {inj_err[6:0],2'b00}
c_en  out  1  one-cycle capture pulse
dump_en  out  NUM_CH  one-hot pop strobe to current channel
serial_vld  out  1  serial_tx valid
serial_tx  out  8  byte to transmitter
run_num  out  8  completed-capture count
cur_ch  out  CH_W  channel being dumped
demo_done  out  1  sticky; all runs complete

Behaviour:
- Reset (async, rst_n=0): state IDLE, run_num=0, cur_ch=0, hdr_idx=0, all strobes/vld 0, serial_tx=0, demo_done=0. Reset mid-transfer abandons the byte; no handshake completes.
- Transfer = serial_vld & serial_rdy. While serial_vld=1 and serial_rdy=0, serial_tx and state are held stable.
- IDLE: start=1 and demo_done=0 -> CAPTURE; else stay.
- CAPTURE (1 cycle): c_en=1; err_en = inj_err[7] & (run_num>=ERR_FIRST) & (run_num<=ERR_LAST), using pre-increment run_num; run_num++ at cycle end; cur_ch=0, hdr_idx=0; -> LABEL.
- LABEL: serial_vld=1; serial_tx = run_num when hdr_idx==2, {(8-CH_W)'0,cur_ch} when hdr_idx==3, else LABEL_BYTE. hdr_idx++ per transfer; transfer with hdr_idx==LABEL_LEN-1 -> DUMP, hdr_idx=0.
- DUMP: serial_vld = ch_out_vld[cur_ch]; serial_tx = ch_out byte of cur_ch; dump_en[cur_ch] = transfer (combinational, same cycle).
- DUMP exit: when ch_out_done[cur_ch]=1 and ch_out_vld[cur_ch]=0 -> TRAIL if SEQ_TRAILER_EN, else NEXT. done with vld=1 still drains the byte first.
- NEXT (1 cycle): if cur_ch==NUM_CH-1, run ends; else cur_ch++, -> LABEL.
- Run end: run_num==NUM_RUNS -> DONE, else -> IDLE.
- DONE: demo_done=1, all strobes 0, serial_vld=0; exit only by reset. start is ignored.
- start deasserted mid-run: run completes; sequencer then parks in IDLE.
- c_en, dump_en, err_en never asserted while demo_done=1. Illegal state encoding -> IDLE.
- Latency, start->first label byte valid: 2 cycles (CAPTURE, then LABEL).

Optional Feature:
- Macro SEQ_TRAILER_EN.
- Defined: running XOR of every data byte transferred in DUMP for cur_ch (cleared on LABEL entry). TRAIL state sends that XOR byte with serial_vld=1, then -> NEXT on transfer.
- Undefined: TRAIL state and XOR register absent; DUMP goes directly to NEXT.

Test Plan:
- Reset and idle: NUM_CH=2, rst_n low mid-LABEL -> all outputs 0 immediately, IDLE after release; start=0 -> no c_en.
- Full run: NUM_CH=2, NUM_RUNS=1, serial_rdy=1; channels give {11,22} and {33} -> stream F0 F0 01 00 11 22 F0 F0 01 01 33; dump_en pulses match each data byte; demo_done=1 afterwards.
- Backpressure: serial_rdy toggles 1-of-3 cycles -> serial_tx stable while vld&!rdy, no byte lost or duplicated, dump_en only on transfer.
- Injection window: inj_err=8'h85, NUM_RUNS=10 -> err_en high in CAPTURE of runs 2..5 only (pre-increment run_num); err_ctrl=9'h014.
- Empty channel: ch_out_done[0]=1, vld=0 at LABEL end -> header sent, zero data bytes, advances to ch1.
- SEQ_TRAILER_EN: data {A5,0F} -> trailer byte AA after 0F; with the macro undefined, no trailer byte is sent.

Source files
------------

// File: rtl/c_d_seq_mc.sv
// Multi-channel capture/dump sequencer: capture pulse, optional error injection, then per-channel
// labelled dumps over a valid/ready serial link. Define SEQ_TRAILER_EN to append an XOR trailer.
module c_d_seq_mc #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned NUM_RUNS   = 10,
  parameter int unsigned LABEL_LEN  = 4,
  parameter logic [7:0]  LABEL_BYTE = 8'hF0,
  parameter int unsigned ERR_FIRST  = 2,
  parameter int unsigned ERR_LAST   = 5,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            inj_err,
  input  logic [8*NUM_CH-1:0]   ch_out,
  input  logic [NUM_CH-1:0]     ch_out_vld,
  input  logic [NUM_CH-1:0]     ch_out_done,
  input  logic                  serial_rdy,
  output logic                  err_en,
  output logic [8:0]            err_ctrl,
  output logic                  c_en,
  output logic [NUM_CH-1:0]     dump_en,
  output logic                  serial_vld,
  output logic [7:0]            serial_tx,
  output logic [7:0]            run_num,
  output logic [CH_W-1:0]       cur_ch,
  output logic                  demo_done
);

  localparam int unsigned HDR_W = $clog2(LABEL_LEN);

  localparam logic [7:0]      ErrFirst = 8'(ERR_FIRST);
  localparam logic [7:0]      ErrLast  = 8'(ERR_LAST);
  localparam logic [7:0]      RunsLast = 8'(NUM_RUNS);
  localparam logic [CH_W-1:0] LastCh   = CH_W'(NUM_CH - 1);
  localparam logic [HDR_W-1:0] HdrLast = HDR_W'(LABEL_LEN - 1);
  localparam logic [HDR_W-1:0] HdrRun  = HDR_W'(2);
  localparam logic [HDR_W-1:0] HdrCh   = HDR_W'(3);

`ifdef SEQ_TRAILER_EN
  typedef enum logic [2:0] {
    StIdle, StCapture, StLabel, StDump, StNext, StDone, StTrail
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StCapture, StLabel, StDump, StNext, StDone
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [7:0]       run_num_q, run_num_d;
  logic [CH_W-1:0]  cur_ch_q, cur_ch_d;
  logic [HDR_W-1:0] hdr_idx_q, hdr_idx_d;
`ifdef SEQ_TRAILER_EN
  logic [7:0]       xor_q, xor_d;
`endif

  logic       cur_vld;
  logic       cur_done;
  logic [7:0] cur_byte;
  logic       xfer;

  // Select the current channel's byte/valid/done without indexing past NUM_CH.
  always_comb begin
    cur_vld  = 1'b0;
    cur_done = 1'b0;
    cur_byte = 8'h00;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (cur_ch_q == CH_W'(c)) begin
        cur_vld  = ch_out_vld[c];
        cur_done = ch_out_done[c];
        cur_byte = ch_out[8*c +: 8];
      end
    end
  end

  always_comb begin
    serial_vld = 1'b0;
    serial_tx  = 8'h00;
    c_en       = 1'b0;
    err_en     = 1'b0;
    dump_en    = '0;
    case (state_q)
      StCapture: begin
        c_en   = 1'b1;
        err_en = inj_err[7] && (run_num_q >= ErrFirst) && (run_num_q <= ErrLast);
      end
      StLabel: begin
        serial_vld = 1'b1;
        if (hdr_idx_q == HdrRun) begin
          serial_tx = run_num_q;
        end else if (hdr_idx_q == HdrCh) begin
          serial_tx = {{(8-CH_W){1'b0}}, cur_ch_q};
        end else begin
          serial_tx = LABEL_BYTE;
        end
      end
      StDump: begin
        serial_vld = cur_vld;
        serial_tx  = cur_byte;
        // Pop strobe fires in the same cycle as the accepted transfer.
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          dump_en[c] = (cur_ch_q == CH_W'(c)) && ch_out_vld[c] && serial_rdy;
        end
      end
`ifdef SEQ_TRAILER_EN
      StTrail: begin
        serial_vld = 1'b1;
        serial_tx  = xor_q;
      end
`endif
      default: ;
    endcase
  end

  assign xfer = serial_vld & serial_rdy;

  always_comb begin
    state_d   = state_q;
    run_num_d = run_num_q;
    cur_ch_d  = cur_ch_q;
    hdr_idx_d = hdr_idx_q;
`ifdef SEQ_TRAILER_EN
    xor_d     = xor_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        run_num_d = run_num_q + 8'd1;
        cur_ch_d  = '0;
        hdr_idx_d = '0;
`ifdef SEQ_TRAILER_EN
        xor_d     = 8'h00;
`endif
        state_d   = StLabel;
      end
      StLabel: begin
        if (xfer) begin
          if (hdr_idx_q == HdrLast) begin
            hdr_idx_d = '0;
            state_d   = StDump;
          end else begin
            hdr_idx_d = hdr_idx_q + HDR_W'(1);
          end
        end
      end
      StDump: begin
        if (xfer) begin
`ifdef SEQ_TRAILER_EN
          xor_d = xor_q ^ cur_byte;
`endif
        end else if (cur_done && !cur_vld) begin
`ifdef SEQ_TRAILER_EN
          state_d = StTrail;
`else
          state_d = StNext;
`endif
        end
      end
`ifdef SEQ_TRAILER_EN
      StTrail: begin
        if (xfer) begin
          state_d = StNext;
        end
      end
`endif
      StNext: begin
        if (cur_ch_q == LastCh) begin
          state_d = (run_num_q == RunsLast) ? StDone : StIdle;
        end else begin
          cur_ch_d  = cur_ch_q + CH_W'(1);
          hdr_idx_d = '0;
`ifdef SEQ_TRAILER_EN
          xor_d     = 8'h00;
`endif
          state_d   = StLabel;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      run_num_q <= 8'h00;
      cur_ch_q  <= '0;
      hdr_idx_q <= '0;
`ifdef SEQ_TRAILER_EN
      xor_q     <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      run_num_q <= run_num_d;
      cur_ch_q  <= cur_ch_d;
      hdr_idx_q <= hdr_idx_d;
`ifdef SEQ_TRAILER_EN
      xor_q     <= xor_d;
`endif
    end
  end

  assign err_ctrl  = {inj_err[6:0], 2'b00};
  assign run_num   = run_num_q;
  assign cur_ch    = cur_ch_q;
  assign demo_done = (state_q == StDone);

endmodule
